// File: rtl/seq_decoder_if.sv
// Control-path bundle between the instruction sequencer and its datapath/memory.
// The decoder drives the strobes and status through 'master'; the environment
// (datapath, memory, run control) uses 'slave'.
interface seq_decoder_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [15:0]      instr;
    logic             mem_rdy;

    logic             mar_load;
    logic             ir_load;
    logic             mdr_load;
    logic             reg_load;
    logic             ram_load;
    logic             incr_pc;
    logic             mem_req;
    logic [1:0]       byte_en;
    logic [2:0]       regr0s;
    logic [2:0]       regr1s;
    logic [2:0]       regws;
    logic [1:0]       mdrs;
    logic [1:0]       op0s;
    logic [1:0]       op1s;
    logic [12:0]      irimm;

    logic [3:0]       state;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr, mem_rdy,
        output mar_load, ir_load, mdr_load, reg_load, ram_load, incr_pc, mem_req,
        output byte_en, regr0s, regr1s, regws, mdrs, op0s, op1s, irimm,
        output state, busy, illegal, timeout, retired
    );

    modport slave (
        output run, instr, mem_rdy,
        input  mar_load, ir_load, mdr_load, reg_load, ram_load, incr_pc, mem_req,
        input  byte_en, regr0s, regr1s, regws, mdrs, op0s, op1s, irimm,
        input  state, busy, illegal, timeout, retired
    );
endinterface

// File: rtl/seq_decoder.sv
// Multi-cycle instruction sequencer: walks fetch / decode / operand read /
// execute / memory wait / write-back and emits the datapath control strobes.
// Memory waits are bounded; an unknown opcode or an over-long wait parks the
// sequencer in a sticky TRAP state until reset.
//
// state  | meaning
// IDLE   | halted, waiting for run
// FETCH  | PC -> MAR, PC incremented
// FETCHW | instruction read in flight, IR loads on mem_rdy
// DECODE | opcode check, immediate -> MDR
// READ   | address operand (R[arg1] + MDR) -> MAR
// EXEC   | store data prepared, or immediate move written back
// EXECW  | data access in flight (store or load)
// WB     | loaded data -> R[tgt]
// TRAP   | illegal opcode or memory timeout, sticky
module seq_decoder #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    seq_decoder_if.master bus
);

    localparam int            WW        = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX);

    localparam logic [2:0] OPC_LOAD  = 3'b000;
    localparam logic [2:0] OPC_STW   = 3'b010;
    localparam logic [2:0] OPC_STB   = 3'b011;
    localparam logic [2:0] OPC_MOVI  = 3'b101;
    localparam logic [2:0] SEL_PC    = 3'b111;

    localparam logic [1:0] MDR_IMM   = 2'd0;
    localparam logic [1:0] MDR_RAM   = 2'd1;
    localparam logic [1:0] MDR_ALU   = 2'd2;
    localparam logic [1:0] OP_R0     = 2'd0;
    localparam logic [1:0] OP_R1     = 2'd1;
    localparam logic [1:0] OP_MDR    = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FETCHW = 4'd2,
        S_DECODE = 4'd3,
        S_READ   = 4'd4,
        S_EXEC   = 4'd5,
        S_EXECW  = 4'd6,
        S_WB     = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wait;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_retired;

    logic [2:0]       w_opc;
    logic [2:0]       w_arg1;
    logic [2:0]       w_tgt;
    logic             w_legal;
    logic             w_store;
    logic             w_wait_last;
    logic             w_instr_end;
    state_t           w_end_next;

    assign w_opc       = bus.instr[15:13];
    assign w_arg1      = bus.instr[5:3];
    assign w_tgt       = bus.instr[2:0];
    assign w_legal     = (w_opc == OPC_LOAD) || (w_opc == OPC_STW) ||
                         (w_opc == OPC_STB)  || (w_opc == OPC_MOVI);
    assign w_store     = (w_opc == OPC_STW) || (w_opc == OPC_STB);
    assign w_wait_last = (r_wait == WAIT_LAST);
    // run only matters here and in IDLE; mid-instruction changes are ignored
    assign w_end_next  = bus.run ? S_FETCH : S_IDLE;

    // Flag the cycle in which the current instruction completes
    always_comb begin
        w_instr_end = 1'b0;
        case (r_state)
            S_EXEC:  w_instr_end = (w_opc == OPC_MOVI);
            S_EXECW: w_instr_end = w_store && bus.mem_rdy;
            S_WB:    w_instr_end = 1'b1;
            default: w_instr_end = 1'b0;
        endcase
    end

    // Sequencer state, bounded memory-wait counter, sticky trap causes, retire count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_instr_end) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_wait  <= '0;
                    r_state <= S_FETCHW;
                end
                S_FETCHW: begin
                    if (bus.mem_rdy) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end else if (w_opc == OPC_MOVI) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_opc == OPC_MOVI) begin
                        r_state <= w_end_next;
                    end else begin
                        r_wait  <= '0;
                        r_state <= S_EXECW;
                    end
                end
                S_EXECW: begin
                    if (bus.mem_rdy) begin
                        r_state <= w_store ? w_end_next : S_WB;
                    end else if (w_wait_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    r_state <= w_end_next;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Zero-extended immediate field, decoded from the IR in every state
    always_comb begin
        bus.irimm = '0;
        case (w_opc)
            OPC_LOAD, OPC_STW, OPC_STB: bus.irimm = {6'd0, bus.instr[12:6]};
            OPC_MOVI:                   bus.irimm = {3'd0, bus.instr[12:3]};
            default:                    bus.irimm = '0;
        endcase
    end

    // Datapath strobes and selects, decoded from state and IR
    always_comb begin
        bus.mar_load = 1'b0;
        bus.ir_load  = 1'b0;
        bus.mdr_load = 1'b0;
        bus.reg_load = 1'b0;
        bus.ram_load = 1'b0;
        bus.incr_pc  = 1'b0;
        bus.mem_req  = 1'b0;
        bus.byte_en  = 2'b11;
        bus.regr0s   = 3'd0;
        bus.regr1s   = 3'd0;
        bus.regws    = 3'd0;
        bus.mdrs     = MDR_IMM;
        bus.op0s     = OP_R0;
        bus.op1s     = OP_R0;
        case (r_state)
            S_FETCH: begin
                bus.regr1s   = SEL_PC;
                bus.op1s     = OP_R1;
                bus.mar_load = 1'b1;
                bus.incr_pc  = 1'b1;
            end
            S_FETCHW: begin
                bus.mem_req = 1'b1;
                bus.ir_load = bus.mem_rdy;
            end
            S_DECODE: begin
                if (w_legal) begin
                    bus.mdrs     = MDR_IMM;
                    bus.mdr_load = 1'b1;
                end
            end
            S_READ: begin
                bus.regr0s   = w_arg1;
                bus.op0s     = OP_MDR;
                bus.op1s     = OP_R0;
                bus.mar_load = 1'b1;
            end
            S_EXEC: begin
                if (w_store) begin
                    bus.mdrs     = MDR_ALU;
                    bus.regr0s   = w_tgt;
                    bus.regr1s   = 3'd0;
                    bus.op0s     = OP_R0;
                    bus.op1s     = OP_R1;
                    bus.mdr_load = 1'b1;
                end else if (w_opc == OPC_MOVI) begin
                    bus.regr1s   = 3'd0;
                    bus.op0s     = OP_MDR;
                    bus.op1s     = OP_R1;
                    bus.regws    = w_tgt;
                    bus.reg_load = 1'b1;
                end
            end
            S_EXECW: begin
                bus.mem_req = 1'b1;
                if (w_store) begin
                    bus.ram_load = 1'b1;
                    bus.byte_en  = (w_opc == OPC_STB) ? 2'b01 : 2'b11;
                end else if (w_opc == OPC_LOAD) begin
                    bus.mdrs     = MDR_RAM;
                    bus.mdr_load = bus.mem_rdy;
                end
            end
            S_WB: begin
                bus.regr1s   = 3'd0;
                bus.op0s     = OP_MDR;
                bus.op1s     = OP_R1;
                bus.regws    = w_tgt;
                bus.reg_load = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Status
    assign bus.state   = r_state;
    assign bus.busy    = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign bus.illegal = r_illegal;
    assign bus.timeout = r_timeout;
    assign bus.retired = r_retired;

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder. A program of instructions (directed cases
// followed by random ones) is expanded up front into a per-cycle list of
// inputs and expected outputs; a driver applies the inputs and an independent
// monitor pops and compares the expectations.
module tb_seq_decoder;

    localparam int WM = 15;
    localparam int CW = 4;

    localparam int S_IDLE   = 0;
    localparam int S_FETCH  = 1;
    localparam int S_FETCHW = 2;
    localparam int S_DECODE = 3;
    localparam int S_READ   = 4;
    localparam int S_EXEC   = 5;
    localparam int S_EXECW  = 6;
    localparam int S_WB     = 7;
    localparam int S_TRAP   = 8;

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] instr;
        logic        rdy;
    } drv_t;

    typedef struct {
        logic [3:0]    state;
        logic          busy;
        logic          illegal;
        logic          timeout;
        logic          mar_load;
        logic          ir_load;
        logic          mdr_load;
        logic          reg_load;
        logic          ram_load;
        logic          incr_pc;
        logic          mem_req;
        logic [1:0]    byte_en;
        logic [2:0]    regr0s;
        logic [2:0]    regr1s;
        logic [2:0]    regws;
        logic [1:0]    mdrs;
        logic [1:0]    op0s;
        logic [1:0]    op1s;
        logic [12:0]   irimm;
        logic [CW-1:0] retired;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seq_decoder_if #(.CNT_W(CW)) bus ();

    seq_decoder #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    drv_t dq[$];
    exp_t eq[$];
    int   n_pushed = 0;
    int   n_app    = 0;
    int   n_chk    = 0;
    int   total    = 0;
    int   bad      = 0;

    // reference model state (architectural view, not the RTL encoding)
    int          m_retired = 0;
    logic [15:0] m_instr   = 16'h0000;
    logic        m_ill     = 1'b0;
    logic        m_to      = 1'b0;
    bit          m_idle    = 1'b1;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(logic [2:0] opc);
        return (opc == 3'b000) || (opc == 3'b010) || (opc == 3'b011) || (opc == 3'b101);
    endfunction

    function automatic logic [12:0] imm_of(logic [15:0] ins);
        logic [2:0] opc;
        opc = ins[15:13];
        if (opc == 3'b000 || opc == 3'b010 || opc == 3'b011) return {6'd0, ins[12:6]};
        if (opc == 3'b101) return {3'd0, ins[12:3]};
        return 13'd0;
    endfunction

    // expected control word for one cycle spent in micro-step 'ph'
    function automatic exp_t expect_for(int ph, logic [15:0] ins, logic rdy);
        exp_t       e;
        logic [2:0] opc;
        bit         store;
        opc        = ins[15:13];
        store      = (opc == 3'b010) || (opc == 3'b011);
        e          = '{default: '0};
        e.byte_en  = 2'b11;
        e.state    = 4'(ph);
        e.busy     = (ph != S_IDLE) && (ph != S_TRAP);
        e.illegal  = m_ill;
        e.timeout  = m_to;
        e.retired  = CW'(m_retired);
        e.irimm    = imm_of(ins);
        case (ph)
            S_FETCH: begin
                e.regr1s = 3'b111; e.op1s = 2'd1; e.mar_load = 1'b1; e.incr_pc = 1'b1;
            end
            S_FETCHW: begin
                e.mem_req = 1'b1; e.ir_load = rdy;
            end
            S_DECODE: begin
                if (is_legal(opc)) e.mdr_load = 1'b1;
            end
            S_READ: begin
                e.regr0s = ins[5:3]; e.op0s = 2'd2; e.op1s = 2'd0; e.mar_load = 1'b1;
            end
            S_EXEC: begin
                if (store) begin
                    e.mdrs = 2'd2; e.regr0s = ins[2:0]; e.op1s = 2'd1; e.mdr_load = 1'b1;
                end else if (opc == 3'b101) begin
                    e.op0s = 2'd2; e.op1s = 2'd1; e.regws = ins[2:0]; e.reg_load = 1'b1;
                end
            end
            S_EXECW: begin
                e.mem_req = 1'b1;
                if (store) begin
                    e.ram_load = 1'b1;
                    e.byte_en  = (opc == 3'b011) ? 2'b01 : 2'b11;
                end else if (opc == 3'b000) begin
                    e.mdrs = 2'd1; e.mdr_load = rdy;
                end
            end
            S_WB: begin
                e.op0s = 2'd2; e.op1s = 2'd1; e.regws = ins[2:0]; e.reg_load = 1'b1;
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    task automatic cyc(int ph, logic run, logic rdy, logic rst = 1'b0);
        drv_t d;
        d.rst   = rst;
        d.run   = run;
        d.instr = m_instr;
        d.rdy   = rdy;
        dq.push_back(d);
        eq.push_back(expect_for(ph, m_instr, rdy));
        n_pushed++;
    endtask

    task automatic go_reset(int idle_after);
        m_retired = 0;
        m_ill     = 1'b0;
        m_to      = 1'b0;
        cyc(S_IDLE, 1'b0, rb(), 1'b1);
        for (int i = 0; i < idle_after; i++) cyc(S_IDLE, 1'b0, rb());
        m_idle = 1'b1;
    endtask

    task automatic end_instr(bit run_after);
        m_retired = (m_retired + 1) % (1 << CW);
        m_idle    = !run_after;
    endtask

    // Expand one instruction into cycles. df/de: wait cycles before mem_rdy in
    // the fetch/data access (df > WM: memory never answers). abort >= 0 resets
    // after that many data-wait cycles.
    task automatic do_instr(logic [15:0] ni, int df, int de, bit run_after, int abort = -1);
        logic [2:0] opc;
        bit         store;
        opc   = ni[15:13];
        store = (opc == 3'b010) || (opc == 3'b011);
        if (m_idle) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) cyc(S_IDLE, 1'b0, rb());
            cyc(S_IDLE, 1'b1, rb());
        end
        m_idle = 1'b0;
        cyc(S_FETCH, rb(), rb());
        if (df > WM) begin
            for (int i = 0; i <= WM; i++) cyc(S_FETCHW, rb(), 1'b0);
            m_to = 1'b1;
            for (int i = 0; i < 4; i++) cyc(S_TRAP, 1'b1, rb());
            return;
        end
        for (int i = 0; i < df; i++) cyc(S_FETCHW, rb(), 1'b0);
        cyc(S_FETCHW, rb(), 1'b1);
        m_instr = ni;
        cyc(S_DECODE, rb(), rb());
        if (!is_legal(opc)) begin
            m_ill = 1'b1;
            for (int i = 0; i < 5; i++) cyc(S_TRAP, 1'b1, rb());
            return;
        end
        if (opc == 3'b101) begin
            cyc(S_EXEC, run_after, rb());
            end_instr(run_after);
            return;
        end
        cyc(S_READ, rb(), rb());
        cyc(S_EXEC, rb(), rb());
        for (int i = 0; i < de; i++) begin
            if (abort == i) begin
                go_reset(2);
                return;
            end
            cyc(S_EXECW, rb(), 1'b0);
        end
        if (store) begin
            cyc(S_EXECW, run_after, 1'b1);
        end else begin
            cyc(S_EXECW, rb(), 1'b1);
            cyc(S_WB, run_after, rb());
        end
        end_instr(run_after);
    endtask

    function automatic logic [15:0] mk_instr(logic [2:0] opc);
        logic [15:0] v;
        v = 16'($urandom);
        v[15:13] = opc;
        return v;
    endfunction

    function automatic int rnd_wait();
        if ($urandom_range(0, 5) == 0) return WM;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n_chk, act, want);
        end
    endtask

    // driver: one program cycle per clock, applied just after the rising edge
    initial begin
        drv_t d;
        forever begin
            @(posedge clk);
            #1;
            if (dq.size() > 0) begin
                d           = dq.pop_front();
                reset       = d.rst;
                bus.run     = d.run;
                bus.instr   = d.instr;
                bus.mem_rdy = d.rdy;
                n_app++;
            end
        end
    end

    // monitor: compares every applied cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_chk < n_app && eq.size() > 0) begin
                e = eq.pop_front();
                chk("state",    32'(bus.state),    32'(e.state));
                chk("busy",     32'(bus.busy),     32'(e.busy));
                chk("illegal",  32'(bus.illegal),  32'(e.illegal));
                chk("timeout",  32'(bus.timeout),  32'(e.timeout));
                chk("retired",  32'(bus.retired),  32'(e.retired));
                chk("mar_load", 32'(bus.mar_load), 32'(e.mar_load));
                chk("ir_load",  32'(bus.ir_load),  32'(e.ir_load));
                chk("mdr_load", 32'(bus.mdr_load), 32'(e.mdr_load));
                chk("reg_load", 32'(bus.reg_load), 32'(e.reg_load));
                chk("ram_load", 32'(bus.ram_load), 32'(e.ram_load));
                chk("incr_pc",  32'(bus.incr_pc),  32'(e.incr_pc));
                chk("mem_req",  32'(bus.mem_req),  32'(e.mem_req));
                chk("byte_en",  32'(bus.byte_en),  32'(e.byte_en));
                chk("regr0s",   32'(bus.regr0s),   32'(e.regr0s));
                chk("regr1s",   32'(bus.regr1s),   32'(e.regr1s));
                chk("regws",    32'(bus.regws),    32'(e.regws));
                chk("mdrs",     32'(bus.mdrs),     32'(e.mdrs));
                chk("op0s",     32'(bus.op0s),     32'(e.op0s));
                chk("op1s",     32'(bus.op1s),     32'(e.op1s));
                chk("irimm",    32'(bus.irimm),    32'(e.irimm));
                n_chk++;
            end
        end
    end

    // program: directed cases, random traffic, then abort / trap scenarios
    initial begin
        logic [2:0] legal_tab [4];
        int         budget;
        legal_tab[0] = 3'b000;
        legal_tab[1] = 3'b010;
        legal_tab[2] = 3'b011;
        legal_tab[3] = 3'b101;
        bus.run     = 1'b0;
        bus.instr   = 16'h0000;
        bus.mem_rdy = 1'b0;

        go_reset(2);
        do_instr(16'hA00B, 0, 0, 1'b1);
        do_instr(mk_instr(3'b000), 0, 3, 1'b1);
        do_instr(mk_instr(3'b011), 1, 2, 1'b0);
        do_instr(mk_instr(3'b010), 2, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            do_instr(mk_instr(legal_tab[$urandom_range(0, 3)]), rnd_wait(), rnd_wait(),
                     $urandom_range(0, 3) != 0);
        end
        do_instr(mk_instr(3'b000), 0, 6, 1'b1, 2);
        do_instr(mk_instr(3'b110), 0, 0, 1'b1);
        go_reset(2);
        do_instr(mk_instr(3'b101), WM + 1, 0, 1'b1);
        go_reset(2);
        do_instr(mk_instr(3'b000), WM, WM, 1'b1);
        do_instr(mk_instr(3'b011), WM, WM, 1'b0);
        for (int i = 0; i < 3; i++) cyc(S_IDLE, 1'b0, rb());

        budget = n_pushed + 100;
        while (n_chk < n_pushed && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        total++;
        if (n_chk != n_pushed) begin
            bad++;
            $display("FAIL drain checked=%0d required=%0d", n_chk, n_pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max memory wait cycles tolerated per access before trap.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  in  1  permits starting the next instruction.
REQ-006 SHALL have port instr  in  16  current IR contents; fields opc=[15:13], arg1=[5:3], tgt=[2:0].
REQ-007 SHALL have port mem_rdy  in  1  memory completes the current access this cycle.
REQ-008 SHALL have ports mar_load, ir_load, mdr_load, reg_load, ram_load, incr_pc, mem_req  out  1 each  control strobes.
REQ-009 SHALL have port byte_en  out  2  byte-lane enable.
REQ-010 SHALL have ports regr0s, regr1s, regws  out  3 each  register read/write selects; 3'b111 = PC.
REQ-011 SHALL have ports mdrs, op0s, op1s  out  2 each  mux selects (mdrs: 0 imm, 1 RAM, 2 ALU; opXs: 0 R0, 1 R1, 2 MDR).
REQ-012 SHALL have port irimm  out  13  zero-extended immediate.
REQ-013 SHALL have ports state  out  4, busy  out  1, illegal  out  1, timeout  out  1, retired  out  CNT_W.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, FETCHW=2, DECODE=3, READ=4, EXEC=5, EXECW=6, WB=7, TRAP=8.
REQ-015 Outputs SHALL be combinational in state and instr; non-asserted defaults: all strobes 0, all selects 0, byte_en=2'b11.
REQ-016 irimm: opc 000/010/011 -> instr[12:6]; opc 101 -> instr[12:3]; otherwise 0; valid in every state.
REQ-017 IDLE: -> FETCH when run=1, else stay.
REQ-018 FETCH: regr1s=3'b111, op1s=1, mar_load=1, incr_pc=1; -> FETCHW.
REQ-019 FETCHW: mem_req=1; ir_load=mem_rdy; -> DECODE on mem_rdy.
REQ-020 DECODE: legal opc (000, 010, 011, 101) -> mdrs=0, mdr_load=1; opc 101 -> EXEC (READ skipped); 000/010/011 -> READ; opc 001/100/110/111 -> TRAP, illegal set.
REQ-021 READ: regr0s=arg1, op0s=2, op1s=0, mar_load=1; -> EXEC.
REQ-022 EXEC opc 010/011: mdrs=2, regr0s=tgt, regr1s=0, op0s=0, op1s=1, mdr_load=1; -> EXECW.
REQ-023 EXEC opc 000: no strobes; -> EXECW.
REQ-024 EXEC opc 101: regr1s=0, op0s=2, op1s=1, regws=tgt, reg_load=1; instruction ends.
REQ-025 EXECW: mem_req=1; opc 010/011 -> ram_load=1, byte_en=2'b01 for 011 else 2'b11, instruction ends on mem_rdy; opc 000 -> mdrs=1, mdr_load=mem_rdy, -> WB on mem_rdy.
REQ-026 WB: regr1s=0, op0s=2, op1s=1, regws=tgt, reg_load=1; instruction ends.
REQ-027 Instruction end: retired increments by 1 (wraps at 2^CNT_W); next state FETCH if run=1, else IDLE.
REQ-028 Wait counter: cleared on entry to FETCHW/EXECW; increments each wait cycle with mem_rdy=0.
REQ-029 If mem_rdy=0 while the wait count equals WAIT_MAX -> TRAP, timeout set; mem_rdy=1 in that same cycle takes priority (no trap).
REQ-030 TRAP: all strobes 0; sticky until reset; illegal/timeout hold their value.
REQ-031 busy=1 in every state except IDLE and TRAP.
REQ-032 run is sampled only in IDLE and at instruction end; deassertion mid-instruction has no effect.

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, retired=0, wait counter=0, illegal=0, timeout=0, regardless of clk.
REQ-034 Reset mid-access SHALL drop mem_req combinationally; after release the FSM SHALL start from IDLE.

Verification
REQ-035 run=1, instr=16'hA00B (opc 101), mem_rdy=1 -> states 1,2,3,5,1; reg_load=1 with regws=3 in EXEC; retired=1.
REQ-036 opc 000 load, mem_rdy delayed 3 cycles in EXECW -> mem_req held 4 cycles; mdr_load only on the rdy cycle; WB reg_load=1; retired +1.
REQ-037 opc 011 store byte -> byte_en=2'b01 and ram_load=1 throughout EXECW; byte_en=2'b11 in all other states.
REQ-038 instr opc 110 in DECODE -> TRAP (state=8), illegal=1; stays in TRAP with run=1 until reset.
REQ-039 mem_rdy=0 for WAIT_MAX+1 cycles in FETCHW -> TRAP, timeout=1; separate run with rdy on cycle WAIT_MAX+1 -> DECODE, no trap.
REQ-040 reset asserted mid-EXECW -> state=0, mem_req=0, retired=0 without a clock edge; run=0 after an instruction -> IDLE, busy=0.
